// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - execute stage: forwarding, ALU, branch resolve, E->M register
// Optional iterative shift-add multiplier enabled by defining EXEC_MUL_EN.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [15:0] RD1_E,
    input  logic [15:0] RD2_E,
    input  logic [15:0] Imm_Ext_E,
    input  logic [15:0] PCE,
    input  logic [15:0] PCPlus4E,
    input  logic [2:0]  RD_E,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    input  logic [15:0] ResultW,
    output logic        PCSrcE,
    output logic [15:0] PCTargetE,
    output logic        BusyE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [2:0]  RD_M,
    output logic [15:0] PCPlus4M,
    output logic [15:0] WriteDataM,
    output logic [15:0] ALU_ResultM
);

    logic [15:0] w_src_a;
    logic [15:0] w_write_data;
    logic [15:0] w_src_b;
    logic [15:0] w_alu_result;
    logic [15:0] w_mul_result;
    logic        w_busy;

    always_comb begin
        case (ForwardA_E)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALU_ResultM;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   w_write_data = ResultW;
            2'b10:   w_write_data = ALU_ResultM;
            default: w_write_data = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_prod;
    logic        w_mul_start;
    logic        w_fsm_busy;
    logic        w_mul_done;

    assign w_mul_start = (ALUControlE == 3'b111) && RegWriteE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_start) w_next_state = S_MUL;
            S_MUL:   if (r_cnt == 4'd15) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_fsm_busy = 1'b0;
        w_mul_done = 1'b0;
        case (r_state)
            S_IDLE:  w_fsm_busy = w_mul_start;
            S_MUL:   w_fsm_busy = 1'b1;
            S_DONE:  w_mul_done = 1'b1;
            default: w_fsm_busy = 1'b0;
        endcase
    end

    // Multiplicand shifts left, multiplier shifts right; one partial product per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_mul_start) begin
                r_cnt    <= '0;
                r_mcand  <= w_src_a;
                r_mplier <= w_src_b;
                r_prod   <= '0;
            end
        end else if (r_state == S_MUL) begin
            r_cnt    <= r_cnt + 4'd1;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : 16'h0000);
        end
    end

    assign w_mul_result = w_mul_done ? r_prod : 16'h0000;
    assign w_busy       = w_fsm_busy && !rst;
`else
    assign w_mul_result = 16'h0000;
    assign w_busy       = 1'b0;
`endif

    always_comb begin
        w_alu_result = 16'h0000;
        case (ALUControlE)
            3'b000: w_alu_result = w_src_a + w_src_b;
            3'b001: w_alu_result = w_src_a - w_src_b;
            3'b010: w_alu_result = w_src_a & w_src_b;
            3'b011: w_alu_result = w_src_a | w_src_b;
            3'b100: w_alu_result = w_src_a ^ w_src_b;
            3'b101: w_alu_result = ($signed(w_src_a) < $signed(w_src_b)) ? 16'h0001 : 16'h0000;
            3'b110: w_alu_result = w_src_a << w_src_b[3:0];
            3'b111: w_alu_result = RegWriteE ? w_mul_result : 16'h0000;
            default: w_alu_result = 16'h0000;
        endcase
    end

    assign PCSrcE    = BranchE && (w_alu_result == 16'h0000);
    assign PCTargetE = PCE + Imm_Ext_E;
    assign BusyE     = w_busy;

    // While the multiplier holds the front end, memory stage sees bubbles.
    always_ff @(posedge clk) begin
        if (rst || w_busy) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= w_write_data;
            ALU_ResultM <= w_alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - table-driven scoreboard bench for execute_cycle
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [15:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [2:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
    logic [15:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [2:0]  RD_M;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardA_E(ForwardA_E),
        .ForwardB_E(ForwardB_E), .ResultW(ResultW), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .BusyE(BusyE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic        alusrc;
        logic [15:0] rd1, rd2, imm;
        logic [1:0]  fa, fb;
        logic [15:0] resw;
        logic        br;
        logic [15:0] pce;
        logic        regw, memw, rsrc;
        logic [2:0]  rd;
        logic [15:0] pc4;
        logic [15:0] e_alu, e_wd;
        logic        e_pcsrc;
        logic [15:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [15:0] alu, wd, pc4;
        logic [2:0]  rd;
        logic        regw, memw, rsrc;
    } m_exp_t;

    vec_t   vecs[$];
    m_exp_t sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic vec_t mk(
        input logic [2:0] ctrl, input logic alusrc, input logic [15:0] rd1, input logic [15:0] rd2,
        input logic [15:0] imm, input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] resw,
        input logic br, input logic [15:0] pce, input logic regw, input logic memw, input logic rsrc,
        input logic [2:0] rd, input logic [15:0] pc4, input logic [15:0] e_alu, input logic [15:0] e_wd,
        input logic e_pcsrc, input logic [15:0] e_tgt);
        vec_t v;
        v.ctrl = ctrl; v.alusrc = alusrc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
        v.fa = fa; v.fb = fb; v.resw = resw; v.br = br; v.pce = pce;
        v.regw = regw; v.memw = memw; v.rsrc = rsrc; v.rd = rd; v.pc4 = pc4;
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUControlE = v.ctrl; ALUSrcE = v.alusrc; RD1_E = v.rd1; RD2_E = v.rd2;
        Imm_Ext_E = v.imm; ForwardA_E = v.fa; ForwardB_E = v.fb; ResultW = v.resw;
        BranchE = v.br; PCE = v.pce; RegWriteE = v.regw; MemWriteE = v.memw;
        ResultSrcE = v.rsrc; RD_E = v.rd; PCPlus4E = v.pc4;
    endtask

    task automatic push_exp(input vec_t v);
        m_exp_t e;
        e.alu = v.e_alu; e.wd = v.e_wd; e.pc4 = v.pc4;
        e.rd = v.rd; e.regw = v.regw; e.memw = v.memw; e.rsrc = v.rsrc;
        sb.push_back(e);
    endtask

    task automatic check_m(input string nm);
        m_exp_t e;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " ALU_ResultM"}, 64'(ALU_ResultM), 64'(e.alu));
            chk({nm, " WriteDataM"},  64'(WriteDataM),  64'(e.wd));
            chk({nm, " PCPlus4M"},    64'(PCPlus4M),    64'(e.pc4));
            chk({nm, " ctrlM"}, 64'({RD_M, RegWriteM, MemWriteM, ResultSrcM}),
                64'({e.rd, e.regw, e.memw, e.rsrc}));
        end
    endtask

    function automatic logic [63:0] m_all();
        return 64'({ALU_ResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM});
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   busy_cnt;
        int   bad_cycles;

        vecs.push_back(mk(3'd0,0,16'hFFFF,16'h0002,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,1,0,0,3'd1,16'h0004, 16'h0001,16'h0002,0,16'h0000));
        vecs.push_back(mk(3'd5,0,16'h8000,16'h0001,16'h0000,2'd0,2'd0,16'h0000,0,16'h0004,1,0,0,3'd2,16'h0008, 16'h0001,16'h0001,0,16'h0004));
        vecs.push_back(mk(3'd6,1,16'h0003,16'h00AA,16'h0011,2'd0,2'd0,16'h0000,0,16'h0010,1,0,1,3'd3,16'h0014, 16'h0006,16'h00AA,0,16'h0021));
        vecs.push_back(mk(3'd0,1,16'h1234,16'h0000,16'h0005,2'd1,2'd0,16'h0010,0,16'h0020,1,0,0,3'd4,16'h0024, 16'h0015,16'h0000,0,16'h0025));
        vecs.push_back(mk(3'd3,0,16'h0100,16'h9999,16'h0000,2'd0,2'd2,16'h7777,0,16'h0030,0,1,0,3'd5,16'h0034, 16'h0115,16'h0015,0,16'h0030));
        vecs.push_back(mk(3'd1,0,16'h0007,16'h0007,16'hFFFC,2'd0,2'd0,16'h0000,1,16'h0100,0,0,0,3'd0,16'h0104, 16'h0000,16'h0007,1,16'h00FC));
        vecs.push_back(mk(3'd1,0,16'h0007,16'h0008,16'hFFFC,2'd0,2'd0,16'h0000,1,16'h0100,0,0,0,3'd0,16'h0104, 16'hFFFF,16'h0008,0,16'h00FC));
        vecs.push_back(mk(3'd2,0,16'hF0F0,16'h3C3C,16'h0000,2'd0,2'd0,16'h0000,0,16'h0200,1,0,0,3'd6,16'h0204, 16'h3030,16'h3C3C,0,16'h0200));
        vecs.push_back(mk(3'd4,0,16'hF0F0,16'h3C3C,16'h0000,2'd0,2'd0,16'h0000,0,16'h0204,1,0,0,3'd7,16'h0208, 16'hCCCC,16'h3C3C,0,16'h0204));
        vecs.push_back(mk(3'd1,1,16'h0000,16'h0055,16'h000C,2'd2,2'd3,16'h1111,1,16'h0208,1,0,0,3'd1,16'h020C, 16'hCCC0,16'h0055,0,16'h0214));
        vecs.push_back(mk(3'd5,0,16'h0001,16'h8000,16'h0000,2'd3,2'd0,16'h0000,1,16'h0300,1,0,0,3'd2,16'h0304, 16'h0000,16'h8000,1,16'h0300));
        vecs.push_back(mk(3'd7,0,16'h0123,16'h0011,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,0,0,0,3'd2,16'h0004, 16'h0000,16'h0011,0,16'h0000));
        vecs.push_back(mk(3'd6,1,16'h0001,16'h0000,16'h000F,2'd0,2'd0,16'h0000,0,16'h0400,1,0,0,3'd3,16'h0404, 16'h8000,16'h0000,0,16'h040F));
        vecs.push_back(mk(3'd0,1,16'h8000,16'h0000,16'h8000,2'd0,2'd0,16'h0000,1,16'hFFF0,1,0,0,3'd4,16'hFFF4, 16'h0000,16'h0000,1,16'h7FF0));

        // Reset with live, non-zero inputs.
        rst = 1'b1;
        drive(mk(3'd0,0,16'h1111,16'h2222,16'h3333,2'd0,2'd0,16'h4444,1,16'h5555,1,1,1,3'd7,16'h6666, 16'h0,16'h0,0,16'h0));
        step();
        chk("reset c1 M outputs", m_all(), 64'd0);
        chk("reset c1 BusyE", 64'(BusyE), 64'd0);
        step();
        chk("reset c2 M outputs", m_all(), 64'd0);
        chk("reset c2 BusyE", 64'(BusyE), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            push_exp(vecs[i]);
            #1;
            chk($sformatf("vec%0d PCSrcE", i), 64'(PCSrcE), 64'(vecs[i].e_pcsrc));
            chk($sformatf("vec%0d PCTargetE", i), 64'(PCTargetE), 64'(vecs[i].e_tgt));
            chk($sformatf("vec%0d BusyE", i), 64'(BusyE), 64'd0);
            step();
            check_m($sformatf("vec%0d", i));
        end

`ifdef EXEC_MUL_EN
        v = mk(3'd7,0,16'h0123,16'h0011,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,1,0,0,3'd5,16'h0040, 16'h1353,16'h0011,0,16'h0000);
        drive(v);
        push_exp(v);
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!BusyE) break;
            busy_cnt++;
            step();
            chk($sformatf("mul bubble %0d", busy_cnt), m_all(), 64'd0);
        end
        chk("mul BusyE cycles", 64'(busy_cnt), 64'd17);
        step();
        check_m("mul result");

        // Second mul aborted by reset during its 8th busy cycle.
        v = mk(3'd7,0,16'h0005,16'h0007,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,1,0,0,3'd6,16'h0080, 16'h0023,16'h0007,0,16'h0000);
        drive(v);
        for (int k = 0; k < 7; k++) step();
        #1;
        chk("mul2 busy at cycle 8", 64'(BusyE), 64'd1);
        rst = 1'b1;
        drive(mk(3'd0,0,16'h0000,16'h0000,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,0,0,0,3'd0,16'h0000, 16'h0,16'h0,0,16'h0));
        step();
        rst = 1'b0;
        #1;
        chk("mul abort M outputs", m_all(), 64'd0);
        chk("mul abort BusyE", 64'(BusyE), 64'd0);
        bad_cycles = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (BusyE !== 1'b0 || m_all() !== 64'd0) bad_cycles++;
        end
        chk("mul abort no late result", 64'(bad_cycles), 64'd0);
`else
        v = mk(3'd7,0,16'h0123,16'h0011,16'h0000,2'd0,2'd0,16'h0000,0,16'h0000,1,0,0,3'd5,16'h0040, 16'h0000,16'h0011,0,16'h0000);
        drive(v);
        push_exp(v);
        busy_cnt = 0;
        #1;
        if (BusyE !== 1'b0) busy_cnt++;
        step();
        check_m("mul disabled");
        for (int k = 0; k < 20; k++) begin
            if (BusyE !== 1'b0) busy_cnt++;
            step();
        end
        chk("mul disabled BusyE cycles", 64'(busy_cnt), 64'd0);
        bad_cycles = 0;
        chk("mul disabled scoreboard drained", 64'(sb.size()), 64'(bad_cycles));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
